fpu_cvt_to_int: RTL and testbench

Pipelined single-precision float to 32-bit integer converter implementing RISC-V FCVT.W.S and FCVT.WU.S. It is the inverse of the FPU's integer-to-float path and sits in the FPU arithmetic sub-module set, fed by the FPU issue logic. It has a two-stage valid/ready pipeline and produces the integer result together with the NV and NX exception flags.

---
 rtl/fpu_cvt_to_int.sv | 164 ++++++++++++++++
 tb/tb_fpu_cvt_to_int.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_cvt_to_int.sv
// Two-stage float (binary32) to 32-bit integer converter for FCVT.W.S / FCVT.WU.S.
// S1 unpacks and aligns the operand; S2 rounds, negates, saturates and registers the result.
module fpu_cvt_to_int (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        is_unsigned_i,
    input  logic [2:0]  rounding_mode_i,
    input  logic [31:0] A_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] result_o,
    output logic [4:0]  flags_o
);

    // Rounding increment for the selected mode; unknown encodings fall back to RNE.
    function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                       input logic lsb, input logic rnd, input logic stk);
        logic inc;
        case (rm)
            3'b001:  inc = 1'b0;
            3'b010:  inc = sign & (rnd | stk);
            3'b011:  inc = ~sign & (rnd | stk);
            3'b100:  inc = rnd;
            default: inc = rnd & (stk | lsb);
        endcase
        return inc;
    endfunction

    logic        s1_en_s, s2_en_s;
    logic        s1_valid_r, s1_sign_r, s1_unsigned_r, s1_nan_r, s1_inf_r, s1_ovf_r;
    logic        s1_round_r, s1_sticky_r;
    logic [2:0]  s1_rm_r;
    logic [31:0] s1_int_r;

    logic [7:0]  exp_s;
    logic [22:0] frac_s;
    logic [5:0]  shamt_s;
    logic [65:0] align_s;
    logic        nan_s, inf_s, ovf_s, round_s, sticky_s;
    logic [31:0] int_s;

    logic        inc_s, inexact_s, nv_s;
    logic [32:0] mag_s;
    logic [31:0] signed_val_s, res_s;

    assign s2_en_s = !valid_o || ready_i;
    assign s1_en_s = !s1_valid_r || s2_en_s;
    assign ready_o = s1_en_s;

    // S1 datapath: classify and align {1,frac} into integer, round and sticky positions.
    always_comb begin
        exp_s    = A_i[30:23];
        frac_s   = A_i[22:0];
        nan_s    = (exp_s == 8'hFF) && (frac_s != 23'd0);
        inf_s    = (exp_s == 8'hFF) && (frac_s == 23'd0);
        ovf_s    = 1'b0;
        int_s    = 32'd0;
        round_s  = 1'b0;
        sticky_s = 1'b0;
        shamt_s  = 6'd0;
        align_s  = 66'd0;
        if (exp_s >= 8'd159) begin
            ovf_s = 1'b1;
        end else if (exp_s < 8'd126) begin
            // |x| < 0.5, subnormals included: only a sticky contribution survives.
            sticky_s = (exp_s != 8'd0) || (frac_s != 23'd0);
        end else begin
            // Bit 34 carries weight 2^0, bit 33 is the round bit, bits 32:0 feed sticky.
            shamt_s  = 6'(exp_s - 8'd116);
            align_s  = {42'd0, 1'b1, frac_s} << shamt_s;
            int_s    = align_s[65:34];
            round_s  = align_s[33];
            sticky_s = |align_s[32:0];
        end
    end

    // S1 register stage: capture the aligned operand on an input transfer.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            s1_valid_r    <= 1'b0;
            s1_sign_r     <= 1'b0;
            s1_unsigned_r <= 1'b0;
            s1_rm_r       <= 3'd0;
            s1_nan_r      <= 1'b0;
            s1_inf_r      <= 1'b0;
            s1_ovf_r      <= 1'b0;
            s1_int_r      <= 32'd0;
            s1_round_r    <= 1'b0;
            s1_sticky_r   <= 1'b0;
        end else if (s1_en_s) begin
            s1_valid_r <= valid_i;
            if (valid_i) begin
                s1_sign_r     <= A_i[31];
                s1_unsigned_r <= is_unsigned_i;
                s1_rm_r       <= rounding_mode_i;
                s1_nan_r      <= nan_s;
                s1_inf_r      <= inf_s;
                s1_ovf_r      <= ovf_s;
                s1_int_r      <= int_s;
                s1_round_r    <= round_s;
                s1_sticky_r   <= sticky_s;
            end
        end
    end

    // S2 datapath: round to a 33-bit magnitude, apply sign, then saturate per mode.
    always_comb begin
        inc_s        = round_inc(s1_rm_r, s1_sign_r, s1_int_r[0], s1_round_r, s1_sticky_r);
        mag_s        = {1'b0, s1_int_r} + {32'd0, inc_s};
        signed_val_s = s1_sign_r ? (32'd0 - mag_s[31:0]) : mag_s[31:0];
        inexact_s    = s1_round_r | s1_sticky_r;
        nv_s         = 1'b0;
        res_s        = signed_val_s;
        if (s1_unsigned_r) begin
            if (s1_nan_r) begin
                nv_s  = 1'b1;
                res_s = 32'hFFFF_FFFF;
            end else if (s1_sign_r) begin
                // A negative value that rounds to zero is only inexact, never invalid.
                nv_s  = s1_inf_r || s1_ovf_r || (mag_s != 33'd0);
                res_s = 32'd0;
            end else if (s1_inf_r || s1_ovf_r || mag_s[32]) begin
                nv_s  = 1'b1;
                res_s = 32'hFFFF_FFFF;
            end else begin
                res_s = mag_s[31:0];
            end
        end else begin
            if (s1_nan_r) begin
                nv_s  = 1'b1;
                res_s = 32'h7FFF_FFFF;
            end else if (s1_inf_r || s1_ovf_r) begin
                nv_s  = 1'b1;
                res_s = s1_sign_r ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else if (!s1_sign_r && (mag_s[32] || mag_s[31])) begin
                nv_s  = 1'b1;
                res_s = 32'h7FFF_FFFF;
            end else if (s1_sign_r && (mag_s > 33'h0_8000_0000)) begin
                nv_s  = 1'b1;
                res_s = 32'h8000_0000;
            end else begin
                res_s = signed_val_s;
            end
        end
    end

    // S2 register stage: output result and flags, held while the consumer stalls.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            valid_o  <= 1'b0;
            result_o <= 32'd0;
            flags_o  <= 5'd0;
        end else if (s2_en_s) begin
            valid_o <= s1_valid_r;
            if (s1_valid_r) begin
                result_o <= res_s;
                flags_o  <= {nv_s, 3'b000, inexact_s & ~nv_s};
            end
        end
    end

endmodule

// File: tb/tb_fpu_cvt_to_int.sv
// Directed-vector bench for fpu_cvt_to_int: rounding, saturation limits,
// back-to-back streaming with backpressure, and mid-flight reset.
module tb_fpu_cvt_to_int;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        valid_i;
    logic        ready_o;
    logic        is_unsigned_i;
    logic [2:0]  rounding_mode_i;
    logic [31:0] A_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic [4:0]  flags_o;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] a;
        logic        uns;
        logic [2:0]  rm;
        logic [31:0] res;
        logic [4:0]  fl;
    } vec_t;

    fpu_cvt_to_int dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .is_unsigned_i   (is_unsigned_i),
        .rounding_mode_i (rounding_mode_i),
        .A_i             (A_i),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .result_o        (result_o),
        .flags_o         (flags_o)
    );

    always #5 clk_i = ~clk_i;

    // Push one operand into an idle pipeline and wait (bounded) for its result.
    task automatic run_op(input logic [31:0] a, input logic uns, input logic [2:0] rm,
                          output logic [31:0] res, output logic [4:0] fl,
                          output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        res = 32'd0;
        fl  = 5'd0;
        @(negedge clk_i);
        A_i             = a;
        is_unsigned_i   = uns;
        rounding_mode_i = rm;
        valid_i         = 1'b1;
        ready_i         = 1'b1;
        #1;
        if (!ready_o) begin
            valid_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        #1 valid_i = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk_i);
            if (valid_o) begin
                lat = i;
                res = result_o;
                fl  = flags_o;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_i         = 1'b0;
        valid_i         = 1'b0;
        ready_i         = 1'b1;
        is_unsigned_i   = 1'b0;
        rounding_mode_i = 3'd0;
        A_i             = 32'd0;
        repeat (3) @(negedge clk_i);
        checks++;
        if (valid_o !== 1'b0 || result_o !== 32'd0 || flags_o !== 5'd0) begin
            errors++;
            $display("FAIL reset_state: valid_o=%b result_o=%h flags_o=%h, required 0/00000000/00",
                     valid_o, result_o, flags_o);
        end
        reset_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: ready_o=%b, required 1", ready_o);
        end
    endtask

    task automatic test_rounding();
        vec_t v [7] = '{
            '{32'h3FC00000, 1'b0, 3'b000, 32'h00000002, 5'h01},
            '{32'h40200000, 1'b0, 3'b000, 32'h00000002, 5'h01},
            '{32'h40200000, 1'b0, 3'b100, 32'h00000003, 5'h01},
            '{32'hBFC00000, 1'b0, 3'b001, 32'hFFFFFFFF, 5'h01},
            '{32'hBFC00000, 1'b0, 3'b010, 32'hFFFFFFFE, 5'h01},
            '{32'h3FC00000, 1'b0, 3'b011, 32'h00000002, 5'h01},
            '{32'hBFC00000, 1'b0, 3'b011, 32'hFFFFFFFF, 5'h01}
        };
        logic [31:0] res;
        logic [4:0]  fl;
        int          lat;
        bit          ok;
        for (int i = 0; i < 7; i++) begin
            run_op(v[i].a, v[i].uns, v[i].rm, res, fl, lat, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rounding[%0d]: no result within bound, required %h/%h", i, v[i].res, v[i].fl);
            end else if (res !== v[i].res || fl !== v[i].fl) begin
                errors++;
                $display("FAIL rounding[%0d]: got %h/%h, required %h/%h", i, res, fl, v[i].res, v[i].fl);
            end
            if (i == 0) begin
                checks++;
                if (lat !== 2) begin
                    errors++;
                    $display("FAIL latency: got %0d cycles, required 2", lat);
                end
            end
        end
    endtask

    task automatic test_signed_limits();
        vec_t v [9] = '{
            '{32'hCF000000, 1'b0, 3'b000, 32'h80000000, 5'h00},
            '{32'h4F000000, 1'b0, 3'b000, 32'h7FFFFFFF, 5'h10},
            '{32'h7FC00000, 1'b0, 3'b000, 32'h7FFFFFFF, 5'h10},
            '{32'hFF800000, 1'b0, 3'b000, 32'h80000000, 5'h10},
            '{32'h7F800000, 1'b0, 3'b000, 32'h7FFFFFFF, 5'h10},
            '{32'h00000000, 1'b0, 3'b000, 32'h00000000, 5'h00},
            '{32'h4EFFFFFF, 1'b0, 3'b000, 32'h7FFFFF80, 5'h00},
            '{32'hCF000001, 1'b0, 3'b000, 32'h80000000, 5'h10},
            '{32'h00000001, 1'b0, 3'b011, 32'h00000001, 5'h01}
        };
        logic [31:0] res;
        logic [4:0]  fl;
        int          lat;
        bit          ok;
        for (int i = 0; i < 9; i++) begin
            run_op(v[i].a, v[i].uns, v[i].rm, res, fl, lat, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL signed_limit[%0d]: no result within bound, required %h/%h", i, v[i].res, v[i].fl);
            end else if (res !== v[i].res || fl !== v[i].fl) begin
                errors++;
                $display("FAIL signed_limit[%0d]: got %h/%h, required %h/%h", i, res, fl, v[i].res, v[i].fl);
            end
        end
    endtask

    task automatic test_unsigned_limits();
        vec_t v [8] = '{
            '{32'h4F7FFFFF, 1'b1, 3'b000, 32'hFFFFFF00, 5'h00},
            '{32'h4F800000, 1'b1, 3'b000, 32'hFFFFFFFF, 5'h10},
            '{32'hBECCCCCD, 1'b1, 3'b001, 32'h00000000, 5'h01},
            '{32'hBECCCCCD, 1'b1, 3'b010, 32'h00000000, 5'h10},
            '{32'h80000000, 1'b1, 3'b000, 32'h00000000, 5'h00},
            '{32'h7FC00000, 1'b1, 3'b000, 32'hFFFFFFFF, 5'h10},
            '{32'hBF800000, 1'b1, 3'b001, 32'h00000000, 5'h10},
            '{32'h3F000000, 1'b1, 3'b000, 32'h00000000, 5'h01}
        };
        logic [31:0] res;
        logic [4:0]  fl;
        int          lat;
        bit          ok;
        for (int i = 0; i < 8; i++) begin
            run_op(v[i].a, v[i].uns, v[i].rm, res, fl, lat, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL unsigned_limit[%0d]: no result within bound, required %h/%h", i, v[i].res, v[i].fl);
            end else if (res !== v[i].res || fl !== v[i].fl) begin
                errors++;
                $display("FAIL unsigned_limit[%0d]: got %h/%h, required %h/%h", i, res, fl, v[i].res, v[i].fl);
            end
        end
    endtask

    task automatic test_reserved_rm();
        logic [2:0]  rms [2] = '{3'b101, 3'b111};
        logic [31:0] res;
        logic [4:0]  fl;
        int          lat;
        bit          ok;
        for (int i = 0; i < 2; i++) begin
            run_op(32'h40200000, 1'b0, rms[i], res, fl, lat, ok);
            checks++;
            if (!ok || res !== 32'h00000002 || fl !== 5'h01) begin
                errors++;
                $display("FAIL reserved_rm[%0d]: ok=%0d got %h/%h, required 00000002/01", i, ok, res, fl);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        int  in_idx    = 0;
        int  out_idx   = 0;
        int  in_flight = 0;
        bit  acc, deliv, exp_ready;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            ready_i = !(c >= 3 && c <= 6);
            if (in_idx < 8) begin
                valid_i         = 1'b1;
                A_i             = ops[in_idx];
                is_unsigned_i   = 1'b0;
                rounding_mode_i = 3'b001;
            end else begin
                valid_i = 1'b0;
            end
            #1;
            exp_ready = !(in_flight == 2 && !ready_i);
            checks++;
            if (ready_o !== exp_ready) begin
                errors++;
                $display("FAIL b2b_ready c=%0d: ready_o=%b, required %b", c, ready_o, exp_ready);
            end
            if (valid_o) begin
                checks++;
                if (out_idx >= 8) begin
                    errors++;
                    $display("FAIL b2b_extra c=%0d: unexpected result %h, required none", c, result_o);
                end else if (result_o !== 32'(out_idx + 1) || flags_o !== 5'h00) begin
                    errors++;
                    $display("FAIL b2b_data c=%0d: got %h/%h, required %h/00",
                             c, result_o, flags_o, 32'(out_idx + 1));
                end
            end
            acc   = valid_i && ready_o;
            deliv = valid_o && ready_i;
            if (acc)   in_idx++;
            if (deliv) out_idx++;
            in_flight = in_flight + (acc ? 1 : 0) - (deliv ? 1 : 0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        checks++;
        if (out_idx !== 8) begin
            errors++;
            $display("FAIL b2b_count: delivered %0d results, required 8", out_idx);
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] res;
        logic [4:0]  fl;
        int          lat;
        bit          ok;
        @(negedge clk_i);
        ready_i         = 1'b0;
        valid_i         = 1'b1;
        is_unsigned_i   = 1'b0;
        rounding_mode_i = 3'b000;
        A_i             = 32'h3F800000;
        @(negedge clk_i);
        A_i = 32'h40000000;
        @(negedge clk_i);
        valid_i = 1'b0;
        checks++;
        if (valid_o !== 1'b1) begin
            errors++;
            $display("FAIL midflight_pre: valid_o=%b, required 1", valid_o);
        end
        #2 reset_i = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || result_o !== 32'd0) begin
            errors++;
            $display("FAIL midflight_async: valid_o=%b result_o=%h, required 0/00000000", valid_o, result_o);
        end
        repeat (2) @(negedge clk_i);
        reset_i = 1'b1;
        ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            checks++;
            if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
                errors++;
                $display("FAIL midflight_after[%0d]: valid_o=%b ready_o=%b, required 0/1", i, valid_o, ready_o);
            end
        end
        run_op(32'h40800000, 1'b0, 3'b000, res, fl, lat, ok);
        checks++;
        if (!ok || res !== 32'h00000004 || fl !== 5'h00) begin
            errors++;
            $display("FAIL midflight_resume: ok=%0d got %h/%h, required 00000004/00", ok, res, fl);
        end
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_signed_limits();
        test_unsigned_limits();
        test_reserved_rm();
        test_back_to_back();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
